// File: rtl/adc084s101_responder.sv
// adc084s101_responder: SPI responder that emulates an ADC084S101 using
// sample values written by fabric logic. Every SPI pin is oversampled in the
// sys_clk domain, and no logic is clocked by SCK.
// Optional build macro ADC_RESP_STATS_EN adds saturating frame counters
// (frames_ok, frames_aborted).
//
// state | meaning
// IDLE  | waiting for CSN fall; spi_miso held at 0
// SHIFT | frame in progress; MOSI captured on SCK rise, MISO advanced on SCK fall
// HOLD  | 16 clocks received; extra SCK edges ignored until CSN rises
module adc084s101_responder #(
  parameter int D_W         = 8,
  parameter int NUM_CHANS   = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(NUM_CHANS)
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_chan,
  input  logic [D_W-1:0] wr_data,
  input  logic          spi_csn,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          frame_done,
  output logic          frame_abort,
  output logic [7:0]    rx_ctrl,
  output logic [CW-1:0] cur_chan
`ifdef ADC_RESP_STATS_EN
  ,
  output logic [15:0]   frames_ok,
  output logic [15:0]   frames_aborted
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // en low is treated exactly like reset
  logic clr;
  assign clr = rst | ~en;

  logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
  logic csn_d, sck_d;
  logic csn_s, sck_s, mosi_s;
  logic csn_fall, csn_rise, sck_rise, sck_fall;

  // Synchronize the SPI pins and keep a delayed copy of the last stage for edge detection
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      csn_sync  <= '1;
      sck_sync  <= '1;
      mosi_sync <= '0;
      csn_d     <= 1'b1;
      sck_d     <= 1'b1;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_d     <= csn_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csn_fall = csn_d & ~csn_s;
  assign csn_rise = ~csn_d & csn_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  logic [D_W-1:0] sample [NUM_CHANS];

  // Sample registers; the CSN-fall snapshot reads the pre-write value naturally
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_CHANS; i++) sample[i] <= '0;
    end else if (wr_en && (int'(wr_chan) < NUM_CHANS)) begin
      sample[wr_chan] <= wr_data;
    end
  end

  logic [D_W-1:0] sel;
  logic [7:0]     field;
  logic [15:0]    load;
  assign sel   = (int'(cur_chan) < NUM_CHANS) ? sample[cur_chan] : '0;
  assign field = 8'(sel) << (8 - D_W);
  assign load  = {4'b0000, field, 4'b0000};

  state_t      state;
  logic [15:0] shift_in, shift_out;
  logic [15:0] shift_next;
  logic [7:0]  ctrl_next;
  logic [4:0]  bit_ctr;
  assign shift_next = {shift_in[14:0], mosi_s};
  assign ctrl_next  = shift_next[15:8];

  // Frame FSM with registered outputs
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state       <= IDLE;
      shift_in    <= '0;
      shift_out   <= '0;
      bit_ctr     <= '0;
      spi_miso    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      rx_ctrl     <= '0;
      cur_chan    <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (csn_fall) begin
            shift_out <= load;
            shift_in  <= '0;
            bit_ctr   <= '0;
            spi_miso  <= load[15];
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // completion wins over a coincident CSN rise
          if (sck_rise && bit_ctr == 5'd15) begin
            shift_in   <= shift_next;
            bit_ctr    <= 5'd16;
            rx_ctrl    <= ctrl_next;
            cur_chan   <= ctrl_next[3 +: CW];
            frame_done <= 1'b1;
            spi_miso   <= 1'b0;
            state      <= csn_rise ? IDLE : HOLD;
          end else if (csn_rise) begin
            frame_abort <= 1'b1;
            spi_miso    <= 1'b0;
            state       <= IDLE;
          end else if (sck_rise) begin
            shift_in <= shift_next;
            bit_ctr  <= bit_ctr + 5'd1;
          end else if (sck_fall && bit_ctr != 5'd0) begin
            shift_out <= {shift_out[14:0], 1'b0};
            spi_miso  <= shift_out[14];
          end
        end
        HOLD: begin
          spi_miso <= 1'b0;
          if (csn_rise) state <= IDLE;
        end
        default: begin
          spi_miso <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef ADC_RESP_STATS_EN
  // Saturating frame statistics
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      frames_ok      <= '0;
      frames_aborted <= '0;
    end else begin
      if (frame_done && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      if (frame_abort && frames_aborted != 16'hFFFF) frames_aborted <= frames_aborted + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc084s101_responder.sv
// Self-checking bench for adc084s101_responder: a task acts as SPI initiator,
// a frame-level model predicts MISO words and frame pulses into queues, and
// independent monitors compare DUT activity against those queues.
module tb_adc084s101_responder;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [7:0] wr_data = '0;
  logic       spi_csn = 1'b1;
  logic       spi_sck = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       frame_done;
  logic       frame_abort;
  logic [7:0] rx_ctrl;
  logic [1:0] cur_chan;
`ifdef ADC_RESP_STATS_EN
  logic [15:0] frames_ok, frames_aborted;
`endif

  adc084s101_responder dut (
    .sys_clk(sys_clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .frame_done(frame_done), .frame_abort(frame_abort),
    .rx_ctrl(rx_ctrl), .cur_chan(cur_chan)
`ifdef ADC_RESP_STATS_EN
    , .frames_ok(frames_ok), .frames_aborted(frames_aborted)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  typedef struct { bit abort; logic [7:0] rx; logic [1:0] ch; } pulse_t;
  typedef struct { logic [15:0] w; int n; } miso_t;
  pulse_t pulse_q[$];
  miso_t  miso_q[$];

  // frame-level reference model
  logic [7:0] mem [4];
  logic [1:0] m_cur = '0;
  logic [7:0] m_rx = '0;
  int m_ok = 0, m_ab = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] d);
    @(negedge sys_clk);
    wr_en = 1'b1; wr_chan = ch; wr_data = d;
    @(negedge sys_clk);
    wr_en = 1'b0;
    mem[ch] = d;
  endtask

  // One CSN-low window with nclk SCK clocks. same_edge raises CSN together with
  // the 16th SCK rise; snap issues a write in the cycle the CSN fall is acted on.
  task automatic run_frame(input logic [7:0] ctrl, input int nclk, input bit same_edge,
                           input bit snap, input logic [1:0] schan, input logic [7:0] sdata);
    logic [15:0] mosi_word;
    miso_t  m;
    pulse_t p;
    mosi_word = {ctrl, 8'($urandom)};
    m.w = {4'b0000, mem[m_cur], 4'b0000};
    m.n = nclk;
    miso_q.push_back(m);
    if (nclk >= 16) begin
      m_rx = ctrl;
      m_cur = ctrl[4:3];
      p.abort = 1'b0;
      m_ok++;
    end else begin
      p.abort = 1'b1;
      m_ab++;
    end
    p.rx = m_rx;
    p.ch = m_cur;
    pulse_q.push_back(p);

    @(negedge sys_clk);
    spi_csn = 1'b0;
    if (snap) begin
      @(posedge sys_clk);
      @(posedge sys_clk);
      @(negedge sys_clk);
      wr_en = 1'b1; wr_chan = schan; wr_data = sdata;
      @(negedge sys_clk);
      wr_en = 1'b0;
      mem[schan] = sdata;
    end
    cyc(6);
    for (int i = 0; i < nclk; i++) begin
      spi_sck = 1'b0;
      spi_mosi = (i < 16) ? mosi_word[15-i] : 1'b0;
      cyc(6);
      spi_sck = 1'b1;
      if (same_edge && nclk == 16 && i == 15) spi_csn = 1'b1;
      cyc(6);
    end
    cyc(2);
    spi_csn = 1'b1;
    cyc(8);
  endtask

  // Monitor: frame_done / frame_abort pulses against the predicted pulse queue
  always @(negedge sys_clk) begin
    if (frame_done || frame_abort) begin
      tests++;
      if (pulse_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: done=%0b abort=%0b expected none", frame_done, frame_abort);
      end else begin
        pulse_t e;
        e = pulse_q.pop_front();
        if ((frame_done && frame_abort) || (frame_abort !== e.abort) ||
            (rx_ctrl !== e.rx) || (cur_chan !== e.ch)) begin
          fails++;
          $display("FAIL frame_pulse: got abort=%0b done=%0b rx=0x%0h ch=%0d expected abort=%0b rx=0x%0h ch=%0d",
                   frame_abort, frame_done, rx_ctrl, cur_chan, e.abort, e.rx, e.ch);
        end
      end
    end
  end

  // Monitor: MISO bits as the initiator sees them at each SCK rise
  initial begin
    logic bits [32];
    int nb;
    logic sl;
    forever begin
      @(negedge spi_csn);
      nb = 0;
      sl = spi_sck;
      forever begin
        @(spi_sck or posedge spi_csn);
        if (spi_sck && !sl) begin
          if (nb < 32) bits[nb] = spi_miso;
          nb++;
        end
        sl = spi_sck;
        if (spi_csn) break;
      end
      tests++;
      if (miso_q.size() == 0) begin
        fails++;
        $display("FAIL miso_frame: got %0d clocks expected no frame", nb);
      end else begin
        miso_t e;
        logic [31:0] got_w, exp_w;
        e = miso_q.pop_front();
        got_w = '0;
        exp_w = '0;
        for (int i = 0; i < nb && i < 32; i++) begin
          got_w = {got_w[30:0], bits[i]};
          exp_w = {exp_w[30:0], (i < 16) ? e.w[15-i] : 1'b0};
        end
        if (nb != e.n || got_w !== exp_w) begin
          fails++;
          $display("FAIL miso_frame: got %0d bits 0x%0h expected %0d bits 0x%0h", nb, got_w, e.n, exp_w);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    cyc(4);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    chk("rst_rx_ctrl", 32'(rx_ctrl), 0);
    chk("rst_cur_chan", 32'(cur_chan), 0);
    rst = 1'b0;
    cyc(3);

    write(2'd0, 8'hA5);
    run_frame(8'h08, 16, 0, 0, 0, 0);          // returns 0x0A50, cur_chan -> 1
    chk("cur_chan_after_f1", 32'(cur_chan), 1);
    write(2'd1, 8'h3C);
    write(2'd2, 8'h81);
    run_frame(8'h10, 16, 0, 0, 0, 0);          // returns 0x3C
    run_frame(8'h00, 16, 0, 0, 0, 0);          // returns 0x81
    chk("cur_chan_after_f3", 32'(cur_chan), 0);

    run_frame(8'h18, 9, 0, 0, 0, 0);           // aborted frame
    chk("abort_keeps_rx", 32'(rx_ctrl), 32'h00);
    chk("abort_keeps_chan", 32'(cur_chan), 0);
    run_frame(8'h00, 16, 0, 0, 0, 0);          // still channel 0

    run_frame(8'h00, 16, 0, 1, 2'd0, 8'h55);   // snapshot sees 0xA5
    run_frame(8'h08, 16, 0, 0, 0, 0);          // now returns 0x55
    run_frame(8'h10, 18, 0, 0, 0, 0);          // extra clocks, single done
    run_frame(8'h00, 16, 1, 0, 0, 0);          // CSN rise with 16th SCK rise
    run_frame(8'h08, 16, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      int r, n;
      if ($urandom_range(0, 1) == 1) write(2'($urandom), 8'($urandom));
      r = $urandom_range(0, 9);
      if (r < 6) n = 16;
      else if (r == 6) n = $urandom_range(17, 20);
      else n = $urandom_range(1, 15);
      run_frame(8'($urandom), n, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), 2'($urandom), 8'($urandom));
    end

`ifdef ADC_RESP_STATS_EN
    chk("frames_ok", 32'(frames_ok), 32'(m_ok));
    chk("frames_aborted", 32'(frames_aborted), 32'(m_ab));
`endif

    // en low behaves as reset: samples, rx_ctrl and cur_chan cleared
    cyc(2);
    en = 1'b0;
    cyc(3);
    chk("en_low_rx_ctrl", 32'(rx_ctrl), 0);
    chk("en_low_cur_chan", 32'(cur_chan), 0);
    chk("en_low_miso", 32'(spi_miso), 0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    m_cur = '0; m_rx = '0; m_ok = 0; m_ab = 0;
`ifdef ADC_RESP_STATS_EN
    chk("en_low_frames_ok", 32'(frames_ok), 0);
    chk("en_low_frames_aborted", 32'(frames_aborted), 0);
`endif
    cyc(3);
    run_frame(8'h08, 16, 0, 0, 0, 0);          // cleared sample
    run_frame(8'h00, 5, 0, 0, 0, 0);
    run_frame(8'h00, 16, 0, 0, 0, 0);
    run_frame(8'h00, 12, 0, 0, 0, 0);
    run_frame(8'h00, 16, 0, 0, 0, 0);
`ifdef ADC_RESP_STATS_EN
    chk("frames_ok_3", 32'(frames_ok), 3);
    chk("frames_aborted_2", 32'(frames_aborted), 2);
    @(negedge sys_clk); rst = 1'b1;
    cyc(2); rst = 1'b0;
    chk("rst_frames_ok", 32'(frames_ok), 0);
    chk("rst_frames_aborted", 32'(frames_aborted), 0);
`endif

    cyc(10);
    chk("pulse_q_drained", 32'(pulse_q.size()), 0);
    chk("miso_q_drained", 32'(miso_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc084s101_responder.md
Name: adc084s101_responder

Overview:
- SPI peripheral (responder) that emulates the ADC084S101 on the far end of the team's ADC SPI link.
- Fabric logic writes per-channel sample values. An external or on-board SPI initiator reads them using the ADC's 16-clock frame format.
- Used for board loopback and for bring-up of the ADC interface without a real converter.
- All SPI inputs are oversampled in the sys_clk domain. No logic is clocked by SCK.

Parameters:
- D_W, 8, sample width. Must be ≤ 8. The sample is placed MSB-first at frame bits [11:12-D_W], and the remaining low bits are zero.
- NUM_CHANS, 4, number of emulated channels (2..4). The address uses $clog2(NUM_CHANS) bits.
- SYNC_STAGES, 2, flip-flop stages in the sck/csn/mosi synchronizers (≥ 2).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  block enable. When low, the block behaves as in reset.
- wr_en  in  1  sample register write strobe
- wr_chan  in  $clog2(NUM_CHANS)  channel to write
- wr_data  in  D_W  sample value
- spi_csn  in  1  chip select from initiator, active low
- spi_sck  in  1  serial clock from initiator, idle high
- spi_mosi  in  1  initiator data (control byte)
- spi_miso  out  1  responder data
- frame_done  out  1  one-cycle pulse when a complete 16-clock frame is received
- frame_abort  out  1  one-cycle pulse when CSN deasserts before 16 rising edges
- rx_ctrl  out  8  control byte from the last completed frame
- cur_chan  out  $clog2(NUM_CHANS)  channel that the next frame will return

Behaviour:
- Reset (rst=1, or en=0):
  - Outputs: spi_miso=0, frame_done=0, frame_abort=0, rx_ctrl=0, cur_chan=0.
  - FSM returns to IDLE.
  - All sample registers are cleared to 0.
  - Synchronizers preset: csn=1, sck=1, mosi=0.
- Synchronization and edge detection:
  - Edges are detected on the last synchronizer stage against a one-cycle-delayed copy.
  - Edge-to-action latency: SYNC_STAGES+1 sys_clk cycles.
  - Timing requirement: SCK high and low phases must each last ≥ SYNC_STAGES+3 sys_clk cycles.
- Sample registers:
  - wr_en writes wr_data into slot wr_chan.
  - A write is accepted at any time.
  - A write in the same cycle as the CSN-fall snapshot is not captured. The snapshot uses the old value.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE, on CSN fall:
    - Load shift_out = {4'b0, sample[cur_chan] aligned, 4'b0}.
    - bit_ctr=0, spi_miso = shift_out[15] (always 0).
    - Go to SHIFT.
  - SHIFT, on SCK rise: shift_in = {shift_in[14:0], mosi}, bit_ctr+1.
  - SHIFT, on SCK fall: shift_out <<= 1, spi_miso = new shift_out[15]. A fall before the first rise is ignored.
  - SHIFT, when bit_ctr reaches 16 (on the 16th rise):
    - rx_ctrl = shift_in[15:8].
    - cur_chan = rx_ctrl[4:3] (ADD1:ADD0), truncated to $clog2(NUM_CHANS) bits. ADD2 is ignored.
    - Pulse frame_done. Go to HOLD.
  - SHIFT, CSN rise before 16 rises:
    - Pulse frame_abort.
    - rx_ctrl and cur_chan are unchanged.
    - spi_miso=0. Go to IDLE.
  - HOLD: spi_miso=0, and extra SCK edges are ignored. On CSN rise, go to IDLE. No pulse is generated.
- Channel pipeline:
  - The address received in frame N selects the data returned in frame N+1.
  - The first frame after reset returns channel 0.
- Simultaneous CSN rise and 16th SCK rise in the same cycle: the frame completes (frame_done), then the FSM goes to IDLE.
- spi_miso is 0 whenever the FSM is not in SHIFT.

Optional Feature:
- Macro ADC_RESP_STATS_EN.
- Defined:
  - Adds outputs frames_ok[15:0] and frames_aborted[15:0].
  - Each is a saturating counter incremented on frame_done / frame_abort respectively.
  - Both clear on reset.
- Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset, write ch0=0xA5, run one frame with ctrl 0x08 → MISO bits = 0000_1010_0101_0000, frame_done pulses once, rx_ctrl=0x08, cur_chan=1.
- Write ch1=0x3C, ch2=0x81; frames with ctrl 0x10, then 0x00 → frame 2 returns 0x3C (per frame 1's 0x08), frame 3 returns 0x81; cur_chan sequence 2, 0.
- Deassert CSN after 9 SCK rises → frame_abort pulses, frame_done stays 0, cur_chan and rx_ctrl unchanged; next full frame returns the previous channel.
- Write ch0=0x55 in the same cycle the CSN fall is detected (ch0 previously 0xA5) → frame returns 0xA5; next frame to ch0 returns 0x55.
- 18 SCK clocks in one CSN-low window → frame_done on the 16th rise only, MISO=0 for clocks 17-18, no abort.
- With ADC_RESP_STATS_EN: 3 good frames plus 2 aborts → frames_ok=3, frames_aborted=2; rst → both 0.
